mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin and 1 = port m0 always wins a tie.
REQ-002 Parameter TIMEOUT, default 1024, meaning the number of BUSY cycles before forced error completion; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all logic on posedge; one clock only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_mem_valid, m1_mem_valid  in  1 each  upstream request.
REQ-006 m0_mem_addr, m1_mem_addr  in  32 each  byte address.
REQ-007 m0_mem_wdata, m1_mem_wdata  in  32 each  write data.
REQ-008 m0_mem_wstrb, m1_mem_wstrb  in  4 each  byte write enables; 0 means read.
REQ-009 m0_mem_ready, m1_mem_ready  out  1 each  one-cycle completion pulse.
REQ-010 m0_mem_rdata, m1_mem_rdata  out  32 each  read data, valid with ready.
REQ-011 m0_mem_error, m1_mem_error  out  1 each  error flag, valid with ready.
REQ-012 mem_valid, mem_addr, mem_wdata, mem_wstrb  out  1/32/32/4  downstream request to one memory-port slave.
REQ-013 mem_ready, mem_rdata, mem_error  in  1/32/1  downstream completion; mem_ready is a one-cycle pulse.

Function
REQ-014 Upstream masters SHALL hold valid, addr, wdata and wstrb stable from assertion until they see their ready pulse, and SHALL drop valid on the following edge.
REQ-015 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-016 In IDLE with no mN_mem_valid high, the block SHALL stay in IDLE and drive mem_valid = 0.
REQ-017 In IDLE with exactly one mN_mem_valid high, the block SHALL grant that port, register its addr/wdata/wstrb onto mem_*, set mem_valid = 1 and go to BUSY.
REQ-018 In IDLE with both valid high and FIXED_PRIORITY = 0, the block SHALL grant the port not granted last; with FIXED_PRIORITY = 1 it SHALL grant m0.
REQ-019 In BUSY, mem_valid and mem_addr/mem_wdata/mem_wstrb SHALL stay constant, and changes on the upstream ports SHALL be ignored.
REQ-020 In BUSY on mem_ready = 1, the block SHALL clear mem_valid and latch mem_rdata/mem_error.
REQ-021 On that same edge it SHALL pulse the granted mN_mem_ready for exactly one cycle (the cycle after mem_ready), with mN_mem_rdata and mN_mem_error equal to the latched values, record the grant as "last granted", and go to DONE.
REQ-022 DONE SHALL last exactly one cycle, ignore all upstream valids, and return to IDLE, so a master's dropped valid is never re-arbitrated.
REQ-023 The non-granted port's ready SHALL remain 0 throughout.
REQ-024 The rdata and error outputs of both ports SHALL hold their last values outside ready pulses.
REQ-025 A BUSY cycle counter SHALL count from 0 on entry to BUSY.
REQ-026 If TIMEOUT > 0 and the counter reaches TIMEOUT-1 without mem_ready, the block SHALL clear mem_valid and complete to the granted port with rdata = 0 and error = 1 via DONE, exactly as in REQ-020/REQ-021.
REQ-027 If mem_ready and timeout expiry coincide, normal completion SHALL win.
REQ-028 The counter SHALL be wide enough for TIMEOUT with no wrap-around before expiry.
REQ-029 mem_ready received in IDLE or DONE SHALL be ignored.
REQ-030 With a single-cycle slave, a master's ready SHALL follow its valid by exactly 3 cycles and back-to-back grants SHALL start no faster than every 4 cycles.
REQ-031 No combinational path SHALL exist from any input to any output; all outputs are registered.

Reset
REQ-032 On reset the block SHALL enter IDLE with the counter cleared.
REQ-033 On reset, "last granted" SHALL be set to m1, so m0 wins the first tie.
REQ-034 On reset, mem_valid, mem_addr, mem_wdata, mem_wstrb, mN_mem_ready, mN_mem_rdata and mN_mem_error SHALL all be 0.
REQ-035 Reset asserted in BUSY SHALL abandon the transaction without any ready pulse, and mem_valid SHALL be 0 on the following cycle.

Verification
REQ-036 Single read: m0 valid, addr=0x10, wstrb=0, slave replies with rdata=0xDEADBEEF -> mem_addr=0x10 one cycle later; m0_mem_ready=1 with rdata=0xDEADBEEF and error=0 exactly 3 cycles after valid; m1 outputs untouched.
REQ-037 Simultaneous requests: m0 and m1 valid in the same cycle, three rounds, FIXED_PRIORITY=0 -> grants m0, m1, m0; with FIXED_PRIORITY=1 -> m0 every time while m0 keeps requesting.
REQ-038 Write with strobes: m1 wdata=0x11223344, wstrb=4'b0101 -> mem_wdata and mem_wstrb match exactly and stay stable until mem_ready; m1 receives one ready pulse.
REQ-039 Timeout: TIMEOUT=8 and the slave never answers -> mem_valid drops after 8 BUSY cycles; the granted port sees ready=1, error=1, rdata=0; a later stray mem_ready in IDLE produces no pulse.
REQ-040 Reset mid-BUSY -> all outputs 0 next cycle, no ready pulse; a subsequent m0/m1 tie grants m0.
REQ-041 Request change during BUSY: m1 changes its addr while m0 is granted -> mem_addr stays unchanged until completion.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter onto one memory-port slave
// Round-robin or fixed-priority grant, BUSY watchdog, fully registered outputs.
module mem_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_mem_valid,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    output logic        m0_mem_error,
    input  logic        m1_mem_valid,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        m1_mem_error,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  busy_cnt_q;
    logic           gnt_q;
    logic           last_q;
    logic           mem_valid_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic [3:0]     mem_wstrb_q;
    logic           m0_ready_q;
    logic           m1_ready_q;
    logic [31:0]    m0_rdata_q;
    logic [31:0]    m1_rdata_q;
    logic           m0_error_q;
    logic           m1_error_q;

    logic           gnt_d;
    logic           timeout_hit;
    logic [31:0]    cpl_rdata;
    logic           cpl_error;

    // gnt_d: 1 selects m1; a tie goes to the port not granted last unless m0 is fixed winner
    always_comb begin
        gnt_d = m1_mem_valid;
        if (m0_mem_valid && m1_mem_valid) begin
            gnt_d = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (busy_cnt_q == CNT_LAST);
    // A real slave answer beats a simultaneous watchdog expiry
    assign cpl_rdata   = mem_ready ? mem_rdata : 32'h0;
    assign cpl_error   = mem_ready ? mem_error : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_cnt_q  <= '0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= 32'h0;
            m1_rdata_q  <= 32'h0;
            m0_error_q  <= 1'b0;
            m1_error_q  <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_mem_valid || m1_mem_valid) begin
                        gnt_q       <= gnt_d;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= gnt_d ? m1_mem_addr  : m0_mem_addr;
                        mem_wdata_q <= gnt_d ? m1_mem_wdata : m0_mem_wdata;
                        mem_wstrb_q <= gnt_d ? m1_mem_wstrb : m0_mem_wstrb;
                        busy_cnt_q  <= '0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready || timeout_hit) begin
                        mem_valid_q <= 1'b0;
                        last_q      <= gnt_q;
                        state_q     <= DONE;
                        if (gnt_q) begin
                            m1_ready_q <= 1'b1;
                            m1_rdata_q <= cpl_rdata;
                            m1_error_q <= cpl_error;
                        end else begin
                            m0_ready_q <= 1'b1;
                            m0_rdata_q <= cpl_rdata;
                            m0_error_q <= cpl_error;
                        end
                    end else begin
                        busy_cnt_q <= busy_cnt_q + CW'(1);
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign m0_mem_ready = m0_ready_q;
    assign m0_mem_rdata = m0_rdata_q;
    assign m0_mem_error = m0_error_q;
    assign m1_mem_ready = m1_ready_q;
    assign m1_mem_rdata = m1_rdata_q;
    assign m1_mem_error = m1_error_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
// Instance 0 is round-robin, instance 1 fixed priority; both use an 8-cycle watchdog.
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        m0v[2], m1v[2], m0r[2], m1r[2], m0e[2], m1e[2];
    logic        mv[2], mr[2], me[2];
    logic [31:0] m0a[2], m1a[2], m0wd[2], m1wd[2], m0rd[2], m1rd[2];
    logic [31:0] ma[2], mwd[2], mrd[2];
    logic [3:0]  m0ws[2], m1ws[2], mws[2];
    logic        slave_en[2], stray[2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl_rd[2][2];
    logic        mdl_er[2][2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.FIXED_PRIORITY(g), .TIMEOUT(8)) u_dut (
            .clk(clk), .reset(reset),
            .m0_mem_valid(m0v[g]), .m0_mem_addr(m0a[g]), .m0_mem_wdata(m0wd[g]),
            .m0_mem_wstrb(m0ws[g]), .m0_mem_ready(m0r[g]), .m0_mem_rdata(m0rd[g]),
            .m0_mem_error(m0e[g]),
            .m1_mem_valid(m1v[g]), .m1_mem_addr(m1a[g]), .m1_mem_wdata(m1wd[g]),
            .m1_mem_wstrb(m1ws[g]), .m1_mem_ready(m1r[g]), .m1_mem_rdata(m1rd[g]),
            .m1_mem_error(m1e[g]),
            .mem_valid(mv[g]), .mem_addr(ma[g]), .mem_wdata(mwd[g]), .mem_wstrb(mws[g]),
            .mem_ready(mr[g]), .mem_rdata(mrd[g]), .mem_error(me[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered slave: answers one cycle after it sees mem_valid; stray forces a pulse
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mr[i] <= (slave_en[i] && mv[i] && !mr[i]) || stray[i];
        end
    end

    typedef struct {
        int          d;
        logic        v0, v1;
        logic [31:0] a0, a1, wd0, wd1;
        logic [3:0]  ws0, ws1;
        logic [31:0] rsp;
        logic        rerr;
        logic        gnt;
        logic        keep;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                mdl_rd[i][p] = 32'h0;
                mdl_er[i][p] = 1'b0;
            end
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          d;
        int          n;
        logic        got, other_seen, unstable;
        logic [31:0] exp_a, exp_wd;
        logic [3:0]  exp_ws;
        logic        gr_rdy;
        logic [31:0] gr_rd, ot_rd;
        logic        gr_er, ot_er;
        d      = v.d;
        exp_a  = v.gnt ? v.a1  : v.a0;
        exp_wd = v.gnt ? v.wd1 : v.wd0;
        exp_ws = v.gnt ? v.ws1 : v.ws0;
        @(negedge clk);
        m0v[d] = v.v0; m0a[d] = v.a0; m0wd[d] = v.wd0; m0ws[d] = v.ws0;
        m1v[d] = v.v1; m1a[d] = v.a1; m1wd[d] = v.wd1; m1ws[d] = v.ws1;
        mrd[d] = v.rsp; me[d] = v.rerr; slave_en[d] = 1'b1;
        n = 0; got = 0; other_seen = 0; unstable = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk($sformatf("v%0d_grant_valid", idx), mv[d], 1);
                chk($sformatf("v%0d_grant_addr", idx), ma[d], exp_a);
                chk($sformatf("v%0d_grant_wdata", idx), mwd[d], exp_wd);
                chk($sformatf("v%0d_grant_wstrb", idx), mws[d], exp_ws);
            end else if (mv[d] && (ma[d] !== exp_a || mwd[d] !== exp_wd || mws[d] !== exp_ws)) begin
                unstable = 1;
            end
            if (v.gnt ? m0r[d] : m1r[d]) other_seen = 1;
            if (v.gnt ? m1r[d] : m0r[d]) got = 1;
        end
        gr_rd = v.gnt ? m1rd[d] : m0rd[d];
        gr_er = v.gnt ? m1e[d]  : m0e[d];
        ot_rd = v.gnt ? m0rd[d] : m1rd[d];
        ot_er = v.gnt ? m0e[d]  : m1e[d];
        chk($sformatf("v%0d_latency", idx), n, 3);
        chk($sformatf("v%0d_other_ready", idx), other_seen, 0);
        chk($sformatf("v%0d_rdata", idx), gr_rd, v.rsp);
        chk($sformatf("v%0d_error", idx), gr_er, v.rerr);
        chk($sformatf("v%0d_other_rdata_hold", idx), ot_rd, mdl_rd[d][v.gnt ? 0 : 1]);
        chk($sformatf("v%0d_other_error_hold", idx), ot_er, mdl_er[d][v.gnt ? 0 : 1]);
        chk($sformatf("v%0d_valid_cleared", idx), mv[d], 0);
        chk($sformatf("v%0d_req_stable", idx), unstable, 0);
        mdl_rd[d][v.gnt ? 1 : 0] = v.rsp;
        mdl_er[d][v.gnt ? 1 : 0] = v.rerr;
        @(negedge clk);
        if (v.gnt) m1v[d] = 1'b0; else m0v[d] = 1'b0;
        if (!v.keep) begin
            m0v[d] = 1'b0;
            m1v[d] = 1'b0;
        end
        @(posedge clk); #1;
        gr_rdy = v.gnt ? m1r[d] : m0r[d];
        chk($sformatf("v%0d_pulse_width", idx), gr_rdy, 0);
    endtask

    initial begin
        int   n, vcnt;
        logic got, bad;
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "stuck");
    end

    initial begin
        int   n, vcnt;
        logic got, bad;
        //               d  v0 v1  a0            a1            wd0           wd1           ws0   ws1   rsp           rerr gnt keep
        vecs[0] = '{0, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'hF, 4'h3, 32'h0000_0001, 0, 0, 1};
        vecs[1] = '{0, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'hF, 4'h3, 32'h0000_0002, 0, 1, 1};
        vecs[2] = '{0, 1, 1, 32'h0000_1000, 32'h0000_2000, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 4'hF, 4'h3, 32'h0000_0003, 1, 0, 1};
        vecs[3] = '{0, 0, 1, 32'h0000_1000, 32'h0000_2000, 32'h0,         32'h1122_3344, 4'h0, 4'b0101, 32'h0000_0055, 0, 1, 1};
        vecs[4] = '{0, 1, 0, 32'h0000_0010, 32'h0000_2000, 32'h0,         32'h0,         4'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1};
        vecs[5] = '{0, 1, 1, 32'h0000_0020, 32'h0000_3000, 32'hC3C3_C3C3, 32'hD4D4_D4D4, 4'h1, 4'h8, 32'h0000_0066, 1, 1, 0};
        vecs[6] = '{1, 1, 1, 32'h0000_4000, 32'h0000_5000, 32'h1234_5678, 32'h8765_4321, 4'hC, 4'h3, 32'h0000_0007, 0, 0, 1};
        vecs[7] = '{1, 1, 1, 32'h0000_4004, 32'h0000_5000, 32'h1234_5678, 32'h8765_4321, 4'hC, 4'h3, 32'h0000_0008, 0, 0, 1};
        vecs[8] = '{1, 0, 1, 32'h0000_4004, 32'h0000_5000, 32'h1234_5678, 32'h8765_4321, 4'hC, 4'h3, 32'h0000_0009, 1, 1, 1};
        vecs[9] = '{1, 1, 1, 32'h0000_4008, 32'h0000_5004, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'h6, 4'h9, 32'h0000_000A, 0, 0, 0};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m0v[i] = 0; m1v[i] = 0; m0a[i] = 0; m1a[i] = 0; m0wd[i] = 0; m1wd[i] = 0;
            m0ws[i] = 0; m1ws[i] = 0; mrd[i] = 0; me[i] = 0; slave_en[i] = 0; stray[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_outputs", i),
                {31'h0, mv[i] | m0r[i] | m1r[i] | m0e[i] | m1e[i]}, 0);
            chk($sformatf("rst%0d_data", i), ma[i] | mwd[i] | {28'h0, mws[i]} | m0rd[i] | m1rd[i], 0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_txn(i, vecs[i]);
        end

        // Watchdog expiry while m1 requests and wiggles its address
        @(negedge clk);
        m0v[0] = 1; m0a[0] = 32'h100; m0ws[0] = 0; slave_en[0] = 0;
        n = 0; vcnt = 0; got = 0; bad = 0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (mv[0]) vcnt++;
            if (mv[0] && ma[0] !== 32'h100) bad = 1;
            if (m1r[0]) bad = 1;
            if (m0r[0]) got = 1;
            if (n == 2) begin m1v[0] = 1; m1a[0] = 32'h200; end
            if (n == 4) m1a[0] = 32'h300;
        end
        chk("to_latency", n, 9);
        chk("to_busy_cycles", vcnt, 8);
        chk("to_addr_held", bad, 0);
        chk("to_rdata", m0rd[0], 0);
        chk("to_error", m0e[0], 1);
        @(negedge clk);
        m0v[0] = 0; m1v[0] = 0;
        repeat (2) @(negedge clk);
        stray[0] = 1;
        @(negedge clk);
        stray[0] = 0;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m0r[0] || m1r[0] || mv[0]) bad = 1;
        end
        chk("stray_ready_ignored", bad, 0);

        // Slave answer on the same edge as expiry
        @(negedge clk);
        m0v[0] = 1; m0a[0] = 32'h180; mrd[0] = 32'hCAFE_F00D; me[0] = 0;
        n = 0; got = 0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (m0r[0]) got = 1;
            if (n == 7) begin @(negedge clk); stray[0] = 1; end
            if (n == 8) begin @(negedge clk); stray[0] = 0; end
        end
        chk("coincide_latency", n, 9);
        chk("coincide_rdata", m0rd[0], 32'hCAFE_F00D);
        chk("coincide_error", m0e[0], 0);
        @(negedge clk);
        m0v[0] = 0;
        repeat (2) @(negedge clk);

        // Reset while BUSY; last grant before this was m0
        m0v[0] = 1; m0a[0] = 32'h40;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("rstbusy_valid", mv[0], 0);
        chk("rstbusy_addr", ma[0], 0);
        chk("rstbusy_ready", {30'h0, m0r[0], m1r[0]}, 0);
        chk("rstbusy_rdata", m0rd[0], 0);
        model_reset();
        @(negedge clk);
        reset = 0; m0v[0] = 0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (m0r[0] || m1r[0] || mv[0]) bad = 1;
        end
        chk("rstbusy_no_pulse", bad, 0);
        run_txn(10, '{0, 1, 1, 32'h0000_0700, 32'h0000_0800, 32'h1, 32'h2, 4'h1, 4'h2,
                      32'h0000_0077, 0, 0, 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
